// File: rtl/regu_intl_pkg.sv
// rtl/regu_intl_pkg.sv - shared types and constants for the regulation interlock scheduler
// Purpose: channel/arbiter state encodings, float width, saturating counter helper.
// Ports: none (package).
package regu_intl_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_PEND   = 2'd2,
    CH_FLIGHT = 2'd3
  } ch_state_e;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ISSUE = 2'd1,
    A_WAIT  = 2'd2
  } arb_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/regu_ch_ctrl.sv
// rtl/regu_ch_ctrl.sv - one regulation channel: set-point change detect and settle delay
// Purpose: tracks one channel through IDLE/DELAY/PEND/FLIGHT.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-low reset
//   i_set_point      live set point of this channel
//   i_delay          settle delay in cycles
//   i_regu_en        channel enable
//   i_block          fault latched (or being latched) - channel may not arm
//   i_grant          arbiter grant strobe (only while pending)
//   i_done           result or timeout for this channel's issue
//   o_pend           channel waits for the shared pipeline
//   o_state          state code
module regu_ch_ctrl
  import regu_intl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [FP_W-1:0] i_set_point,
  input  logic [31:0]     i_delay,
  input  logic            i_regu_en,
  input  logic            i_block,
  input  logic            i_grant,
  input  logic            i_done,
  output logic            o_pend,
  output logic [1:0]      o_state
);

  ch_state_e       state_q, state_d;
  logic [FP_W-1:0] sp_q;
  logic [31:0]     cnt_q, cnt_d;
  logic            rearm_q, rearm_d;
  logic            sp_chg;

  assign sp_chg = (sp_q != i_set_point);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= CH_IDLE;
      sp_q    <= '0;
      cnt_q   <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= i_set_point;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    unique case (state_q)
      CH_IDLE: begin
        if (sp_chg && i_regu_en && !i_block) begin
          state_d = CH_DELAY;
          cnt_d   = '0;
        end
      end
      CH_DELAY: begin
        if (!i_regu_en) begin
          state_d = CH_IDLE;
        end else if (sp_chg) begin
          cnt_d = '0;
        end else if (cnt_q >= i_delay) begin
          state_d = CH_PEND;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      CH_PEND: begin
        // A grant already committed the arbiter to this channel, so it wins;
        // a coincident set-point change is carried as a re-arm instead.
        if (i_grant) begin
          state_d = CH_FLIGHT;
          rearm_d = sp_chg;
        end else if (!i_regu_en) begin
          state_d = CH_IDLE;
        end else if (sp_chg) begin
          state_d = CH_DELAY;
          cnt_d   = '0;
        end
      end
      CH_FLIGHT: begin
        if (sp_chg) rearm_d = 1'b1;
        if (i_done) begin
          rearm_d = 1'b0;
          cnt_d   = '0;
          state_d = (i_regu_en && (rearm_q || sp_chg) && !i_block) ? CH_DELAY : CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  assign o_pend  = (state_q == CH_PEND);
  assign o_state = state_q;

endmodule

// File: rtl/regu_intl_sched.sv
// rtl/regu_intl_sched.sv - round-robin scheduler sharing one float compare pipeline
// Purpose: N_CH regulation channels arbitrate for one subtract/abs/compare pipeline;
//          results latch per-channel faults and last |A-B|.
// Ports:
//   i_clk, i_rst                          clock, asynchronous active-low reset
//   i_data/i_set_point/i_diff/i_delay     per-channel 32-bit fields, channel k at [32k+31:32k]
//   i_regu_en, i_clr                      per-channel enable and fault clear
//   o_fp_a/o_fp_b/o_fp_diff/o_fp_valid    issue to the shared pipeline
//   i_fp_abs/i_fp_gt/i_fp_valid           pipeline result
//   o_regu_flag/o_regu_sub/o_ch_state     per-channel fault, last |A-B|, state
//   o_busy, o_fp_err                      issue in flight, sticky watchdog timeout
module regu_intl_sched
  import regu_intl_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TMO  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [FP_W*N_CH-1:0] i_data,
  input  logic [FP_W*N_CH-1:0] i_set_point,
  input  logic [FP_W*N_CH-1:0] i_diff,
  input  logic [32*N_CH-1:0]   i_delay,
  input  logic [N_CH-1:0]      i_regu_en,
  input  logic [N_CH-1:0]      i_clr,
  output logic [FP_W-1:0]      o_fp_a,
  output logic [FP_W-1:0]      o_fp_b,
  output logic                 o_fp_valid,
  input  logic [FP_W-1:0]      i_fp_abs,
  input  logic                 i_fp_gt,
  input  logic                 i_fp_valid,
  output logic [FP_W-1:0]      o_fp_diff,
  output logic [N_CH-1:0]      o_regu_flag,
  output logic [FP_W*N_CH-1:0] o_regu_sub,
  output logic [2*N_CH-1:0]    o_ch_state,
  output logic                 o_busy,
  output logic                 o_fp_err
);

  localparam int IW = $clog2(N_CH);
  localparam int WW = $clog2(TMO + 1);

  arb_state_e          arb_q, arb_d;
  logic [IW-1:0]       last_q, last_d, gidx_q, gidx_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [FP_W-1:0]     diff_q;
  logic                err_q;
  logic [N_CH-1:0]     flag_q;
  logic [FP_W*N_CH-1:0] sub_q;

  logic [N_CH-1:0]     pend, grant, done, set_flag;
  logic                res_ok, tmo_hit;
  logic                pick_found;
  logic [IW-1:0]       pick, cand;
  logic [FP_W-1:0]     a_sel, b_sel, diff_sel;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    regu_ch_ctrl u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_set_point (i_set_point[k*FP_W +: FP_W]),
      .i_delay     (i_delay[k*32 +: 32]),
      .i_regu_en   (i_regu_en[k]),
      .i_block     (flag_q[k] | set_flag[k]),
      .i_grant     (grant[k]),
      .i_done      (done[k]),
      .o_pend      (pend[k]),
      .o_state     (o_ch_state[2*k +: 2])
    );
  end

  // Scan from the farthest offset down so the nearest pending channel after
  // last_q is the one left in pick.
  always_comb begin
    pick_found = 1'b0;
    pick       = last_q;
    cand       = last_q;
    for (int off = N_CH; off >= 1; off--) begin
      cand = IW'((int'(last_q) + off) % N_CH);
      if (pend[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  assign a_sel    = i_set_point[int'(gidx_q)*FP_W +: FP_W];
  assign b_sel    = i_data[int'(gidx_q)*FP_W +: FP_W];
  assign diff_sel = i_diff[int'(gidx_q)*FP_W +: FP_W];

  always_comb begin
    arb_d   = arb_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    wcnt_d  = wcnt_q;
    grant   = '0;
    done    = '0;
    res_ok  = 1'b0;
    tmo_hit = 1'b0;
    unique case (arb_q)
      A_IDLE: begin
        if (pick_found) begin
          arb_d       = A_ISSUE;
          last_d      = pick;
          gidx_d      = pick;
          grant[pick] = 1'b1;
        end
      end
      A_ISSUE: begin
        arb_d  = A_WAIT;
        wcnt_d = WW'(1);
      end
      A_WAIT: begin
        if (i_fp_valid) begin
          arb_d        = A_IDLE;
          res_ok       = 1'b1;
          done[gidx_q] = 1'b1;
        end else if (wcnt_q >= WW'(TMO - 1)) begin
          // the counter would reach TMO on this edge
          arb_d        = A_IDLE;
          tmo_hit      = 1'b1;
          done[gidx_q] = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: arb_d = A_IDLE;
    endcase
  end

  // Results for a channel disabled while in flight are dropped.
  assign set_flag = (res_ok && i_fp_gt) ? (done & i_regu_en) : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      arb_q  <= A_IDLE;
      last_q <= IW'(N_CH - 1);
      gidx_q <= '0;
      wcnt_q <= '0;
      diff_q <= '0;
      err_q  <= 1'b0;
      flag_q <= '0;
      sub_q  <= '0;
    end else begin
      arb_q  <= arb_d;
      last_q <= last_d;
      gidx_q <= gidx_d;
      wcnt_q <= wcnt_d;
      if (arb_q == A_ISSUE) diff_q <= diff_sel;
      if (tmo_hit) err_q <= 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        if (set_flag[k]) flag_q[k] <= 1'b1;
        else if (i_clr[k]) flag_q[k] <= 1'b0;
        if (res_ok && done[k] && i_regu_en[k]) sub_q[k*FP_W +: FP_W] <= i_fp_abs;
      end
    end
  end

  assign o_fp_valid  = (arb_q == A_ISSUE);
  assign o_fp_a      = (arb_q == A_ISSUE) ? a_sel : '0;
  assign o_fp_b      = (arb_q == A_ISSUE) ? b_sel : '0;
  assign o_fp_diff   = (arb_q == A_ISSUE) ? diff_sel : (arb_q == A_WAIT) ? diff_q : '0;
  assign o_busy      = (arb_q != A_IDLE);
  assign o_fp_err    = err_q;
  assign o_regu_flag = flag_q;
  assign o_regu_sub  = sub_q;

endmodule

// File: tb/tb_regu_intl_sched.sv
// tb/tb_regu_intl_sched.sv - self-checking bench for regu_intl_sched
module tb_regu_intl_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data, sp, diff, dly;
  logic [3:0]   en, clr;
  logic [31:0]  fp_a, fp_b, fp_diff, fp_abs;
  logic         fp_valid_o, fp_gt, fp_valid;
  logic [3:0]   flag;
  logic [127:0] sub;
  logic [7:0]   ch_state;
  logic         busy, fp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  regu_intl_sched #(.N_CH(4), .TMO(64)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_set_point(sp), .i_diff(diff),
    .i_delay(dly), .i_regu_en(en), .i_clr(clr), .o_fp_a(fp_a), .o_fp_b(fp_b),
    .o_fp_valid(fp_valid_o), .i_fp_abs(fp_abs), .i_fp_gt(fp_gt), .i_fp_valid(fp_valid),
    .o_fp_diff(fp_diff), .o_regu_flag(flag), .o_regu_sub(sub), .o_ch_state(ch_state),
    .o_busy(busy), .o_fp_err(fp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pipeline stub and issue log. Result = a^b unless a fixed value is requested.
  int          issue_cyc[$];
  logic [31:0] issue_a[$], issue_b[$], issue_d[$];
  bit          stub_en = 1'b1, stub_gt = 1'b0, stub_fix = 1'b0, force_v = 1'b0, force_gt = 1'b0;
  int          stub_lat = 2, stub_cnt = 0;
  logic [31:0] stub_abs, fix_abs;

  always @(negedge clk) begin
    fp_valid = force_v;
    fp_gt    = force_gt;
    fp_abs   = 32'h0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        fp_valid = 1'b1;
        fp_gt    = stub_gt;
        fp_abs   = stub_abs;
      end
    end
    if (fp_valid_o === 1'b1) begin
      issue_cyc.push_back(cyc);
      issue_a.push_back(fp_a);
      issue_b.push_back(fp_b);
      issue_d.push_back(fp_diff);
      stub_abs = stub_fix ? fix_abs : (fp_a ^ fp_b);
      if (stub_en) stub_cnt = stub_lat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit");
  end

  int mdl_last = 3;  // round-robin pointer of the reference model
  int mdl_n    = 0;  // issues expected so far

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int icyc(input int n);
    return (n < issue_cyc.size()) ? issue_cyc[n] : -1;
  endfunction
  function automatic logic [31:0] ia(input int n);
    return (n < issue_a.size()) ? issue_a[n] : 32'hDEAD_BEEF;
  endfunction

  function automatic int rr_next(input int last, input logic [3:0] m);
    for (int j = 1; j <= 4; j++) if (m[(last + j) % 4]) return (last + j) % 4;
    return -1;
  endfunction

  task automatic chg(input int k);
    logic [23:0] r;
    r = 24'($urandom) | 24'h1;
    sp[k*32 +: 32] = sp[k*32 +: 32] ^ {8'h0, r};
  endtask

  function automatic logic [1:0] st(input int k);
    return ch_state[2*k +: 2];
  endfunction

  // Four channels reach PEND together; the model orders them by round robin
  // and spaces issues by latency + 2.
  task automatic all_four();
    int d, lat, t, c, ch;
    logic [3:0] m;
    int ord[4], ec[4];
    d   = $urandom_range(0, 4);
    lat = $urandom_range(1, 4);
    for (int k = 0; k < 4; k++) dly[k*32 +: 32] = 32'(d);
    stub_lat = lat;
    stub_gt  = 1'b0;
    @(negedge clk);
    t = cyc;
    for (int k = 0; k < 4; k++) chg(k);
    m = 4'hF;
    c = t + d + 3;
    for (int n = 0; n < 4; n++) begin
      ch = rr_next(mdl_last, m);
      ord[n] = ch; ec[n] = c; m[ch] = 1'b0; mdl_last = ch; c = c + lat + 2;
    end
    to_neg(ec[3] + lat + 2);
    for (int n = 0; n < 4; n++) begin
      chk("rr_cycle", icyc(mdl_n + n), ec[n]);
      chk("rr_opa", ia(mdl_n + n), sp[ord[n]*32 +: 32]);
      chk("rr_opb", (mdl_n + n < issue_b.size()) ? issue_b[mdl_n + n] : 32'hDEAD_BEEF, data[ord[n]*32 +: 32]);
      chk("rr_diff", (mdl_n + n < issue_d.size()) ? issue_d[mdl_n + n] : 32'hDEAD_BEEF, diff[ord[n]*32 +: 32]);
      chk("rr_sub", sub[ord[n]*32 +: 32], sp[ord[n]*32 +: 32] ^ data[ord[n]*32 +: 32]);
    end
    mdl_n += 4;
    chk("rr_flags", 32'(flag), 32'h0);
    chk("rr_states", 32'(ch_state), 32'h0);
  endtask

  int t, i, r, s, lat, d;

  initial begin
    rst_n = 1'b0; en = '0; clr = '0; dly = '0;
    for (int k = 0; k < 4; k++) begin
      sp[k*32 +: 32]   = {8'(k + 1), 24'($urandom)};
      data[k*32 +: 32] = $urandom;
      diff[k*32 +: 32] = $urandom;
    end
    sp[31:0] = 32'h4120_0000;
    repeat (3) @(negedge clk);
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_sub", sub[31:0] | sub[63:32] | sub[95:64] | sub[127:96], 32'h0);
    chk("rst_state", 32'(ch_state), 32'h0);
    chk("rst_busy_valid_err", {29'h0, busy, fp_valid_o, fp_err}, 32'h0);
    chk("rst_opa", fp_a | fp_b | fp_diff, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(ch_state), 32'h0);
    en = 4'hF;

    // All four pending together: order 0,1,2,3 from reset
    all_four();

    // Ch0: 0x41200000 -> 0x41300000, delay 10, fault reported
    en[0] = 1'b0;
    sp[31:0] = 32'h4120_0000;
    repeat (2) @(negedge clk);
    en[0] = 1'b1; dly[31:0] = 32'd10; stub_lat = 2; stub_gt = 1'b1;
    stub_fix = 1'b1; fix_abs = 32'h3F80_0000;
    @(negedge clk);
    t = cyc;
    sp[31:0] = 32'h4130_0000;
    i = t + 13;
    mdl_last = 0;
    to_neg(i + 1);
    chk("c0_issue_cycle", icyc(mdl_n), i);
    chk("c0_opa", ia(mdl_n), 32'h4130_0000);
    chk("c0_busy", 32'(busy), 32'h1);
    chk("c0_diff_held", fp_diff, diff[31:0]);
    chk("c0_flight", 32'(st(0)), 32'h3);
    to_neg(i + 2);
    chk("c0_flag_not_yet", 32'(flag[0]), 32'h0);
    to_neg(i + 3);
    chk("c0_flag", 32'(flag[0]), 32'h1);
    chk("c0_sub", sub[31:0], 32'h3F80_0000);
    chk("c0_idle", 32'(st(0)), 32'h0);
    mdl_n++;
    stub_fix = 1'b0;
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    @(negedge clk);
    chk("c0_clr", 32'(flag[0]), 32'h0);

    // Repeat: round robin continues after ch0
    all_four();

    // Ch1 fault blocks re-arm until cleared; clear coincident with set loses
    d = $urandom_range(0, 5); lat = $urandom_range(1, 3);
    dly[63:32] = 32'(d); stub_lat = lat; stub_gt = 1'b1;
    @(negedge clk);
    t = cyc; chg(1);
    i = t + d + 3;
    to_neg(i + lat + 1);
    chk("c1_issue_cycle", icyc(mdl_n), i);
    chk("c1_flag", 32'(flag[1]), 32'h1);
    mdl_n++; mdl_last = 1;
    t = cyc; chg(1);
    to_neg(t + d + 6);
    chk("c1_blocked_state", 32'(st(1)), 32'h0);
    chk("c1_blocked_noissue", 32'(issue_cyc.size()), 32'(mdl_n));
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    chk("c1_cleared", 32'(flag[1]), 32'h0);
    t = cyc; chg(1);
    i = t + d + 3;
    to_neg(i + lat);
    clr[1] = 1'b1;
    to_neg(i + lat + 1);
    clr[1] = 1'b0;
    chk("c1_rearm_issue", icyc(mdl_n), i);
    chk("c1_set_wins", 32'(flag[1]), 32'h1);
    mdl_n++;

    // Ch2 restart in DELAY and re-arm after a change in FLIGHT
    dly[95:64] = 32'd20; stub_lat = 4; stub_gt = 1'b0;
    @(negedge clk);
    t = cyc; chg(2);
    to_neg(t + 1);
    chk("c2_delay", 32'(st(2)), 32'h1);
    to_neg(t + 6);
    s = cyc; chg(2);
    to_neg(s + 21);
    chk("c2_still_delay", 32'(st(2)), 32'h1);
    to_neg(s + 22);
    chk("c2_pend", 32'(st(2)), 32'h2);
    i = s + 23;
    to_neg(i + 1);
    chk("c2_issue_cycle", icyc(mdl_n), i);
    chg(2);
    r = i + 4;
    to_neg(r + 1);
    chk("c2_rearm_delay", 32'(st(2)), 32'h1);
    to_neg(r + 24);
    chk("c2_reissue_cycle", icyc(mdl_n + 1), r + 23);
    chk("c2_reissue_opa", ia(mdl_n + 1), sp[95:64]);
    mdl_n += 2; mdl_last = 2;
    to_neg(r + 30);

    // Enable dropped in DELAY
    dly[127:96] = 32'd10;
    t = cyc; chg(3);
    to_neg(t + 3);
    en[3] = 1'b0;
    to_neg(t + 4);
    chk("c3_en_drop", 32'(st(3)), 32'h0);
    to_neg(t + 15);
    chk("c3_no_issue", 32'(issue_cyc.size()), 32'(mdl_n));
    en[3] = 1'b1;

    // Watchdog timeout, then the next pending channel is served
    stub_en = 1'b0; dly[127:96] = 32'd0; dly[31:0] = 32'd0;
    @(negedge clk);
    t = cyc; chg(3);
    i = t + 3;
    to_neg(t + 10);
    chg(0);
    to_neg(i + 63);
    chk("tmo_err_before", 32'(fp_err), 32'h0);
    chk("tmo_busy_before", 32'(busy), 32'h1);
    to_neg(i + 64);
    chk("tmo_err", 32'(fp_err), 32'h1);
    chk("tmo_busy_drop", 32'(busy), 32'h0);
    chk("tmo_ch3_idle", 32'(st(3)), 32'h0);
    chk("tmo_no_flag", 32'(flag[3]), 32'h0);
    stub_en = 1'b1; stub_lat = 2; stub_gt = 1'b0;
    to_neg(i + 66);
    chk("tmo_next_issue", icyc(mdl_n + 1), i + 65);
    chk("tmo_next_opa", ia(mdl_n + 1), sp[31:0]);
    mdl_n += 2; mdl_last = 0;
    to_neg(i + 72);

    // Reset during A_WAIT, then a late result
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0; stub_en = 1'b0; dly[63:32] = 32'd0;
    @(negedge clk);
    t = cyc; chg(1);
    to_neg(t + 5);
    chk("rst_mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0; en = '0;
    to_neg(t + 6);
    chk("rst_mid_flag", 32'(flag), 32'h0);
    chk("rst_mid_sub", sub[31:0] | sub[63:32] | sub[95:64] | sub[127:96], 32'h0);
    chk("rst_mid_err_busy", {30'h0, busy, fp_err}, 32'h0);
    chk("rst_mid_state", 32'(ch_state), 32'h0);
    to_neg(t + 7);
    rst_n = 1'b1;
    @(posedge clk); #1;
    force_v = 1'b1; force_gt = 1'b1;
    @(posedge clk); #1;
    force_v = 1'b0; force_gt = 1'b0;
    @(negedge clk);
    chk("late_flag", 32'(flag), 32'h0);
    chk("late_sub", sub[63:32], 32'h0);
    chk("late_busy_err", {30'h0, busy, fp_err}, 32'h0);
    chk("late_state", 32'(ch_state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regu_intl_sched.md
# regu_intl_sched

Shared-pipeline scheduler for output-regulation interlocks. Holds N_CH independent regulation channels, each with a set-point-change detector and settle-delay timer. Channels that finish their delay are granted round-robin access to one external floating-point subtract→abs→compare-greater pipeline. The returned compare result latches per-channel regulation faults. It replaces one dedicated floating-point pipeline per interlock in the MPS interlock block.

## Interface
Parameters:
- N_CH, 4, number of regulation channels (2..8).
- TMO, 64, watchdog limit in cycles from issue to pipeline result.

Ports:
- i_clk  in  1  single system clock.
- i_rst  in  1  asynchronous active-low reset.
- i_data  in  32*N_CH  per-channel measured value, IEEE-754 single; channel k = bits [32k+31:32k].
- i_set_point  in  32*N_CH  per-channel set point, float.
- i_diff  in  32*N_CH  per-channel allowed error, float.
- i_delay  in  32*N_CH  per-channel settle delay, cycles, unsigned.
- i_regu_en  in  N_CH  per-channel enable.
- i_clr  in  N_CH  per-channel fault clear.
- o_fp_a  out  32  operand A (set point) to shared pipeline.
- o_fp_b  out  32  operand B (data) to shared pipeline.
- o_fp_valid  out  1  one-cycle issue strobe.
- i_fp_abs  in  32  |A−B| from pipeline.
- i_fp_gt  in  1  |A−B| > diff of issued channel.
- i_fp_valid  in  1  result strobe.
- o_fp_diff  out  32  i_diff of the granted channel; held stable while the issue is in flight.
- o_regu_flag  out  N_CH  sticky regulation fault per channel.
- o_regu_sub  out  32*N_CH  last |A−B| per channel.
- o_ch_state  out  2*N_CH  per-channel state code.
- o_busy  out  1  an issue is in flight.
- o_fp_err  out  1  sticky watchdog timeout; cleared only by reset.

## Operation
- Per-channel states: IDLE=0, DELAY=1, PEND=2, FLIGHT=3.
- Each channel registers its i_set_point every cycle. sp_chg is high when the registered copy differs from the live input.
- IDLE→DELAY: on sp_chg & i_regu_en & ~o_regu_flag. The delay counter clears.
- DELAY: the counter increments each cycle. sp_chg restarts the counter at 0.
- DELAY→PEND: when count ≥ i_delay.
- PEND→DELAY: on sp_chg, with the counter restarted.
- PEND→FLIGHT: when granted.
- FLIGHT→IDLE: on i_fp_valid, or on watchdog timeout.
- FLIGHT with sp_chg: the channel goes to DELAY after the result instead of IDLE. The pending sp_chg is remembered in a 1-bit flag.
- i_regu_en low: DELAY or PEND channel → IDLE immediately. In FLIGHT, the result is discarded on arrival and the channel goes to IDLE.
- Arbiter states: A_IDLE, A_ISSUE, A_WAIT.
  - A_IDLE: round-robin over PEND channels, starting at last_grant+1 mod N_CH.
  - A_ISSUE: drives o_fp_valid=1 for one cycle with o_fp_a/o_fp_b/o_fp_diff from the granted channel, sampled that cycle.
  - A_WAIT: holds o_fp_diff until i_fp_valid or timeout, then → A_IDLE.
- Only one issue is in flight at a time. i_fp_valid outside A_WAIT is ignored.
- Result handling, if the channel is still enabled:
  - o_regu_sub[k] ← i_fp_abs.
  - If i_fp_gt: o_regu_flag[k] ← 1.
- i_clr[k] clears o_regu_flag[k]. If a set and i_clr land on the same cycle, set wins.
- While o_regu_flag[k]=1 the channel cannot leave IDLE.
- Timeout: the wait counter reaches TMO → o_fp_err=1. The channel goes to IDLE with no flag update.

## Timing
- Reset: all outputs 0; all channels IDLE; last_grant = N_CH−1, so channel 0 is served first.
- Cycle t: set point changes. t+1: sp_chg seen, channel → DELAY. PEND at t+2+i_delay. i_delay=0 gives PEND at t+2.
- Grant to o_fp_valid: 1 cycle, PEND→A_ISSUE.
- i_fp_valid at cycle r: o_regu_flag and o_regu_sub update at r+1; the arbiter can grant again at r+1; o_fp_valid again at r+2 at the earliest.
- Delay counter saturates at 0xFFFFFFFF.
- Reset asserted mid-flight: everything returns to reset values. A late i_fp_valid after reset is ignored.

## Structure
- Package regu_intl_pkg holds:
  - channel state codes CH_IDLE/CH_DELAY/CH_PEND/CH_FLIGHT;
  - arbiter states A_IDLE/A_ISSUE/A_WAIT;
  - float width constant FP_W=32.
- Sub-module regu_ch_ctrl, one instance per channel, holds:
  - set-point register, delay counter, state, and the post-flight re-arm bit;
  - inputs: grant and result-done strobes;
  - outputs: pend and state.
- The top level holds the round-robin arbiter, operand mux, watchdog counter, and the flag/sub registers.

## Test plan
- Ch0 set point 0x41200000→0x41300000, i_delay=10, stub returns i_fp_gt=1, abs=0x3F800000 → o_fp_valid at change+13; o_regu_flag[0]=1 and o_regu_sub[0]=0x3F800000 one cycle after i_fp_valid.
- Ch0–3 all reach PEND the same cycle → issues ordered 0,1,2,3. Repeat → order continues from last_grant+1.
- Ch1 flagged; change set point again → ch1 stays IDLE. Pulse i_clr[1], then change set point → ch1 re-arms. i_clr coincident with i_fp_gt=1 → flag stays 1.
- Ch2 set point changes again while in DELAY (count=5, i_delay=20) → PEND occurs 22 cycles after the second change. A change during FLIGHT → ch2 re-enters DELAY after the result.
- Stub never returns i_fp_valid, TMO=64 → o_fp_err=1 at issue+64, o_busy drops, next PEND channel is granted.
- i_rst low during A_WAIT, then a late i_fp_valid → all outputs 0 and no flag set.
